// File: rtl/fetch_seq_if.sv
// fetch_seq_if: fetch-sequencer request/response bundle; perf counters present only with FETCH_SEQ_PERF_EN.
interface fetch_seq_if;
  logic        i_stall;
  logic        i_br_valid;
  logic [31:0] i_br_target;
  logic        i_eret_req;
  logic [31:0] i_epc;
  logic        i_exc_req;
  logic [31:0] o_fetch_pc;
  logic        o_flush;
  logic        o_redirect_pending;
  logic        o_in_handler;
  logic        o_adel_f;
`ifdef FETCH_SEQ_PERF_EN
  logic [31:0] o_perf_redirects;
  logic [31:0] o_perf_stall_cycles;
`endif
  modport slave (
    input  i_stall, i_br_valid, i_br_target, i_eret_req, i_epc, i_exc_req,
    output o_fetch_pc, o_flush, o_redirect_pending, o_in_handler, o_adel_f
`ifdef FETCH_SEQ_PERF_EN
    , output o_perf_redirects, o_perf_stall_cycles
`endif
  );
  modport master (
    output i_stall, i_br_valid, i_br_target, i_eret_req, i_epc, i_exc_req,
    input  o_fetch_pc, o_flush, o_redirect_pending, o_in_handler, o_adel_f
`ifdef FETCH_SEQ_PERF_EN
    , input o_perf_redirects, o_perf_stall_cycles
`endif
  );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the fetch PC; exception > ERET > branch > +4, buffers stalled redirects.
// Optional FETCH_SEQ_PERF_EN adds redirect and stall-cycle counters.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_PC   = 32'h0000_4180,
  parameter logic [31:0] TEXT_LO  = 32'h0000_3000,
  parameter logic [31:0] TEXT_HI  = 32'h0000_6FFF
) (
  input  logic        clk,
  input  logic        reset,
  fetch_seq_if.slave  bus
);
  typedef enum logic {RUN, PEND} state_t;
  state_t      r_state, w_state_nx;
  logic [31:0] r_fetch_pc, w_pc_nx;
  logic [31:0] r_pend_target, w_pend_nx;
  logic        r_flush;
  logic        r_in_handler, w_in_handler_nx;
  logic        w_nonseq;
  logic        w_req;
  logic [31:0] w_req_target;
  assign w_req        = bus.i_eret_req | bus.i_br_valid;
  assign w_req_target = bus.i_eret_req ? bus.i_epc : bus.i_br_target;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= RUN;
      r_fetch_pc    <= RESET_PC;
      r_pend_target <= '0;
      r_flush       <= 1'b0;
      r_in_handler  <= 1'b0;
    end else begin
      r_state       <= w_state_nx;
      r_fetch_pc    <= w_pc_nx;
      r_pend_target <= w_pend_nx;
      r_flush       <= bus.i_exc_req;
      r_in_handler  <= w_in_handler_nx;
    end
  end
  always_comb begin
    w_state_nx      = r_state;
    w_pc_nx         = r_fetch_pc;
    w_pend_nx       = r_pend_target;
    w_in_handler_nx = r_in_handler;
    w_nonseq        = 1'b0;
    if (bus.i_exc_req) begin
      w_pc_nx         = EXC_PC;
      w_in_handler_nx = 1'b1;
      w_state_nx      = RUN;
      w_nonseq        = 1'b1;
    end else if (w_req) begin
      w_in_handler_nx = bus.i_eret_req ? 1'b0 : r_in_handler;
      w_state_nx      = bus.i_stall ? PEND : RUN;
      w_pend_nx       = bus.i_stall ? w_req_target : r_pend_target;
      w_pc_nx         = bus.i_stall ? r_fetch_pc : w_req_target;
      w_nonseq        = ~bus.i_stall;
    end else if (!bus.i_stall) begin
      w_state_nx = RUN;
      w_pc_nx    = (r_state == PEND) ? r_pend_target : r_fetch_pc + 32'd4;
      w_nonseq   = (r_state == PEND);
    end
  end
  assign bus.o_fetch_pc         = r_fetch_pc;
  assign bus.o_flush            = r_flush;
  assign bus.o_redirect_pending = (r_state == PEND);
  assign bus.o_in_handler       = r_in_handler;
  assign bus.o_adel_f           = (r_fetch_pc[1:0] != 2'b00) || (r_fetch_pc < TEXT_LO) || (r_fetch_pc > TEXT_HI);
`ifdef FETCH_SEQ_PERF_EN
  logic [31:0] r_perf_redirects, r_perf_stall_cycles;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_perf_redirects    <= '0;
      r_perf_stall_cycles <= '0;
    end else begin
      r_perf_redirects    <= r_perf_redirects + {31'd0, w_nonseq};
      r_perf_stall_cycles <= r_perf_stall_cycles + {31'd0, bus.i_stall & ~bus.i_exc_req};
    end
  end
  assign bus.o_perf_redirects    = r_perf_redirects;
  assign bus.o_perf_stall_cycles = r_perf_stall_cycles;
`endif
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed vectors with hand-computed fetch PC / status expectations.
module tb_fetch_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  fetch_seq_if bus ();
  fetch_sequencer dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic stall, input logic br, input logic [31:0] bt,
                       input logic eret, input logic [31:0] epc, input logic exc);
    bus.i_stall     = stall;
    bus.i_br_valid  = br;
    bus.i_br_target = bt;
    bus.i_eret_req  = eret;
    bus.i_epc       = epc;
    bus.i_exc_req   = exc;
  endtask
  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask
  initial begin
    idle();
    #12;
    chk("rst_pc", bus.o_fetch_pc, 32'h3000);
    chk("rst_flush", {31'd0, bus.o_flush}, 32'd0);
    chk("rst_pend", {31'd0, bus.o_redirect_pending}, 32'd0);
    chk("rst_inh", {31'd0, bus.o_in_handler}, 32'd0);
    chk("rst_adel", {31'd0, bus.o_adel_f}, 32'd0);
    reset = 1'b1;
    step(); chk("seq1", bus.o_fetch_pc, 32'h3004);
    step(); chk("seq2", bus.o_fetch_pc, 32'h3008);
    step(); chk("seq3", bus.o_fetch_pc, 32'h300C);
    chk("seq_adel", {31'd0, bus.o_adel_f}, 32'd0);
    drive(1'b1, 1'b1, 32'h3100, 1'b0, 32'h0, 1'b0);
    step(); chk("stall1_pc", bus.o_fetch_pc, 32'h300C);
    chk("stall1_pend", {31'd0, bus.o_redirect_pending}, 32'd1);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    step(); chk("stall2_pc", bus.o_fetch_pc, 32'h300C);
    step(); chk("stall3_pc", bus.o_fetch_pc, 32'h300C);
    chk("stall3_pend", {31'd0, bus.o_redirect_pending}, 32'd1);
    idle();
    step(); chk("release_pc", bus.o_fetch_pc, 32'h3100);
    chk("release_pend", {31'd0, bus.o_redirect_pending}, 32'd0);
`ifdef FETCH_SEQ_PERF_EN
    chk("perf_redir", bus.o_perf_redirects, 32'd1);
    chk("perf_stall", bus.o_perf_stall_cycles, 32'd3);
`endif
    drive(1'b1, 1'b1, 32'h3200, 1'b0, 32'h0, 1'b0);
    step(); chk("pre_exc_pend", {31'd0, bus.o_redirect_pending}, 32'd1);
    drive(1'b1, 1'b1, 32'h3200, 1'b0, 32'h0, 1'b1);
    step(); chk("exc_pc", bus.o_fetch_pc, 32'h4180);
    chk("exc_flush", {31'd0, bus.o_flush}, 32'd1);
    chk("exc_inh", {31'd0, bus.o_in_handler}, 32'd1);
    chk("exc_pend", {31'd0, bus.o_redirect_pending}, 32'd0);
    idle();
    step(); chk("post_exc_flush", {31'd0, bus.o_flush}, 32'd0);
    chk("post_exc_pc", bus.o_fetch_pc, 32'h4184);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h3024, 1'b0);
    step(); chk("eret_pc", bus.o_fetch_pc, 32'h3024);
    chk("eret_inh", {31'd0, bus.o_in_handler}, 32'd0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    step(); chk("exc2_inh", {31'd0, bus.o_in_handler}, 32'd1);
    drive(1'b1, 1'b1, 32'h3700, 1'b1, 32'h3600, 1'b0);
    step(); chk("eret_st_pc", bus.o_fetch_pc, 32'h4180);
    chk("eret_st_inh", {31'd0, bus.o_in_handler}, 32'd0);
    chk("eret_st_pend", {31'd0, bus.o_redirect_pending}, 32'd1);
    idle();
    step(); chk("eret_rel_pc", bus.o_fetch_pc, 32'h3600);
    drive(1'b0, 1'b1, 32'h3002, 1'b0, 32'h0, 1'b0);
    step(); chk("mis_pc", bus.o_fetch_pc, 32'h3002);
    chk("mis_adel", {31'd0, bus.o_adel_f}, 32'd1);
    drive(1'b0, 1'b1, 32'h7000, 1'b0, 32'h0, 1'b0);
    step(); chk("hi_adel", {31'd0, bus.o_adel_f}, 32'd1);
    drive(1'b0, 1'b1, 32'h6FFC, 1'b0, 32'h0, 1'b0);
    step(); chk("top_adel", {31'd0, bus.o_adel_f}, 32'd0);
    drive(1'b0, 1'b1, 32'h2FFC, 1'b0, 32'h0, 1'b0);
    step(); chk("lo_adel", {31'd0, bus.o_adel_f}, 32'd1);
    drive(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0);
    step(); idle();
    step(); chk("wrap_pc", bus.o_fetch_pc, 32'h0);
    chk("wrap_adel", {31'd0, bus.o_adel_f}, 32'd1);
    drive(1'b1, 1'b1, 32'h3300, 1'b0, 32'h0, 1'b0);
    step(); drive(1'b1, 1'b1, 32'h3400, 1'b0, 32'h0, 1'b0);
    step(); idle();
    step(); chk("latest_pc", bus.o_fetch_pc, 32'h3400);
    drive(1'b1, 1'b1, 32'h3500, 1'b0, 32'h0, 1'b0);
    step(); drive(1'b0, 1'b1, 32'h3800, 1'b0, 32'h0, 1'b0);
    step(); chk("pend_direct_pc", bus.o_fetch_pc, 32'h3800);
    chk("pend_direct_st", {31'd0, bus.o_redirect_pending}, 32'd0);
    drive(1'b1, 1'b1, 32'h3900, 1'b0, 32'h0, 1'b0);
    step(); chk("pre_rst_pend", {31'd0, bus.o_redirect_pending}, 32'd1);
    reset = 1'b0;
    #1;
    chk("async_rst_pc", bus.o_fetch_pc, 32'h3000);
    chk("async_rst_pend", {31'd0, bus.o_redirect_pending}, 32'd0);
    idle();
    #1;
    reset = 1'b1;
    step(); chk("post_rst_pc", bus.o_fetch_pc, 32'h3004);
    chk("post_rst_pend", {31'd0, bus.o_redirect_pending}, 32'd0);
`ifdef FETCH_SEQ_PERF_EN
    chk("perf_rst", bus.o_perf_redirects, 32'd0);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
